// File: rtl/noc_params.sv
// Shared NoC parameter package.
// Supplies the router-wide sizes (PORT_NUM, VC_NUM, VC_SIZE), the flit
// types with and without a VC field, the reset credit depth used by the
// output arbiters, the arbiter state enum, and a round-robin pointer helper.
package noc_params;

  localparam int PORT_NUM     = 9;
  localparam int VC_NUM       = 2;
  localparam int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_W       = 16;
  localparam int CREDIT_DEPTH = 4;
  localparam int PORT_W       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [DATA_W-1:0] data;
  } flit_novc_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Port index that follows p in round-robin order.
  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(PORT_NUM - 1)) ? '0 : p + PORT_W'(1);
  endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Bundle between the router input ports / downstream link and one output
// arbiter.
//   req_i        : per-input request, held with in_flit_i until granted
//   in_flit_i    : per-input flit without VC field
//   grant_o      : one-hot grant, flit consumed in the same cycle
//   credit_ret_i : one credit returned per asserted VC bit
//   out_valid_o  : registered output flit valid
//   out_flit_o   : registered output flit with allocated vc_id
//   locked_o     : packet in flight
//   err_o        : sticky protocol error
// slave is the arbiter side; master is the driver side.
interface noc_output_arbiter_if;
  import noc_params::*;

  logic [PORT_NUM-1:0]             req_i;
  flit_novc_t [PORT_NUM-1:0]       in_flit_i;
  logic [PORT_NUM-1:0]             grant_o;
  logic [VC_NUM-1:0]               credit_ret_i;
  logic                            out_valid_o;
  flit_t                           out_flit_o;
  logic                            locked_o;
  logic                            err_o;

  modport slave (
    input  req_i, in_flit_i, credit_ret_i,
    output grant_o, out_valid_o, out_flit_o, locked_o, err_o
  );

  modport master (
    output req_i, in_flit_i, credit_ret_i,
    input  grant_o, out_valid_o, out_flit_o, locked_o, err_o
  );

endinterface

// File: rtl/noc_output_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index this cycle (kept by the parent)
//   gnt : one-hot grant to the first request at or after ptr, wrapping
//   any : at least one request present
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is inferred.
    gnt = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port controller for the mesh router.
// Round-robin shares the output between the input ports, holds it for a
// whole packet (HEAD..TAIL), allocates a downstream VC per packet, tracks
// per-VC credits and emits a registered flit with vc_id inserted.
//   clk, rst_n : clock, asynchronous active-low reset
//   arb        : noc_output_arbiter_if.slave (requests, flits, grants,
//                credit returns, registered output flit, locked/err status)
// Optional build macro: NOC_OUT_ARB_ERR_CHECK_EN enables the sticky
// protocol error flag; otherwise err_o is tied low.
module noc_output_arbiter
  import noc_params::*;
#(
  parameter int CREDIT_DEPTH = noc_params::CREDIT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  noc_output_arbiter_if.slave  arb
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_LOCKED = LOCKED;

  logic [0:0]          state_q, state_d;
  logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]   owner_q, owner_d;
  logic [VC_SIZE-1:0]  cur_vc_q, cur_vc_d;
  logic [CW-1:0]       credits_q [VC_NUM];
  logic [CW-1:0]       credits_d [VC_NUM];
  logic                out_valid_q;
  flit_t               out_flit_q;

  logic [PORT_NUM-1:0] cand, rr_gnt, grant;
  logic                rr_any, vc_avail, gnt_any;
  logic [PORT_W-1:0]   win_idx, gnt_idx;
  logic [VC_SIZE-1:0]  sel_vc, gnt_vc;
  flit_novc_t          owner_flit, gnt_flit;

  // Only packet starts compete for a free output.
  always_comb begin
    cand = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      cand[i] = arb.req_i[i] && (arb.in_flit_i[i].flit_label == HEAD ||
                                 arb.in_flit_i[i].flit_label == HEADTAIL);
    end
  end

  rr_arbiter #(.N(PORT_NUM)) u_rr (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .any (rr_any)
  );

  // Winner index and lowest-index VC with credit left.
  always_comb begin
    win_idx  = '0;
    vc_avail = 1'b0;
    sel_vc   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (rr_gnt[i]) win_idx = PORT_W'(i);
    end
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (credits_q[v] != '0) begin
        vc_avail = 1'b1;
        sel_vc   = VC_SIZE'(v);
      end
    end
  end

  assign owner_flit = arb.in_flit_i[owner_q];

  always_comb begin
    grant  = '0;
    gnt_vc = '0;
    if (state_q == S_IDLE) begin
      if (rr_any && vc_avail) begin
        grant  = rr_gnt;
        gnt_vc = sel_vc;
      end
    end else begin
      // A locked output only carries the rest of the owner's packet.
      if (arb.req_i[owner_q] && credits_q[cur_vc_q] != '0 &&
          (owner_flit.flit_label == BODY || owner_flit.flit_label == TAIL)) begin
        grant[owner_q] = 1'b1;
        gnt_vc         = cur_vc_q;
      end
    end
    if (!rst_n) grant = '0;
  end

  assign gnt_any     = |grant;
  assign gnt_idx     = (state_q == S_IDLE) ? win_idx : owner_q;
  assign gnt_flit    = arb.in_flit_i[gnt_idx];
  assign arb.grant_o = grant;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cur_vc_d = cur_vc_q;
    if (gnt_any) begin
      if (state_q == S_IDLE) begin
        rr_ptr_d = next_port(win_idx);
        if (gnt_flit.flit_label == HEAD) begin
          state_d  = S_LOCKED;
          owner_d  = win_idx;
          cur_vc_d = sel_vc;
        end
      end else if (gnt_flit.flit_label == TAIL) begin
        state_d  = S_IDLE;
        rr_ptr_d = next_port(owner_q);
      end
    end
  end

  // A grant and a return on the same VC cancel; returns saturate at depth.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      credits_d[v] = credits_q[v];
      if (gnt_any && gnt_vc == VC_SIZE'(v)) begin
        if (!arb.credit_ret_i[v]) credits_d[v] = credits_q[v] - CW'(1);
      end else if (arb.credit_ret_i[v] && credits_q[v] != CW'(CREDIT_DEPTH)) begin
        credits_d[v] = credits_q[v] + CW'(1);
      end
    end
  end

  // NOTE: the credit counters are a small register array, not a memory, and
  // must come out of reset at full depth, so they are reset like any flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cur_vc_q    <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      for (int v = 0; v < VC_NUM; v++) credits_q[v] <= CW'(CREDIT_DEPTH);
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cur_vc_q    <= cur_vc_d;
      out_valid_q <= gnt_any;
      if (gnt_any) begin
        out_flit_q <= '{flit_label: gnt_flit.flit_label, vc_id: gnt_vc,
                        data: gnt_flit.data};
      end
      for (int v = 0; v < VC_NUM; v++) credits_q[v] <= credits_d[v];
    end
  end

  assign arb.out_valid_o = out_valid_q;
  assign arb.out_flit_o  = out_flit_q;
  assign arb.locked_o    = (state_q == S_LOCKED);

`ifdef NOC_OUT_ARB_ERR_CHECK_EN
  logic proto_err;
  logic err_q;

  always_comb begin
    proto_err = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      // A return on a full counter that is not offset by a grant overflows.
      if (arb.credit_ret_i[v] && credits_q[v] == CW'(CREDIT_DEPTH) &&
          !(gnt_any && gnt_vc == VC_SIZE'(v))) proto_err = 1'b1;
    end
    if (state_q == S_IDLE) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (arb.req_i[i] && (arb.in_flit_i[i].flit_label == BODY ||
                             arb.in_flit_i[i].flit_label == TAIL)) proto_err = 1'b1;
      end
    end else if (arb.req_i[owner_q] && (owner_flit.flit_label == HEAD ||
                                        owner_flit.flit_label == HEADTAIL)) begin
      proto_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | proto_err;
  end

  assign arb.err_o = err_q;
`else
  assign arb.err_o = 1'b0;
`endif

endmodule
